// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings and helpers for the data-memory controller: access-size enum,
// registered load context, lane/byte-enable generation and the load formatter.
package dmem_ctrl_pkg;

  localparam int DMEM_DEPTH_LOG2 = 10;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_type_e;

  // Everything the formatter needs one cycle after the RAM word was captured.
  typedef struct packed {
    logic [1:0] lane;
    mem_type_e  mtype;
    logic       sign;
  } rd_ctx_t;

  function automatic logic is_aligned(mem_type_e t, logic [1:0] lane);
    case (t)
      MEM_HALF: return ~lane[0];
      MEM_WORD: return lane == 2'b00;
      default:  return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(mem_type_e t, logic [1:0] lane);
    case (t)
      MEM_BYTE: return 4'b0001 << lane;
      MEM_HALF: return 4'b0011 << {lane[1], 1'b0};
      MEM_WORD: return 4'b1111;
      default:  return 4'b0000;
    endcase
  endfunction

  // Store data is right-justified; replicate it so every enabled lane sees its bytes.
  function automatic logic [31:0] lane_data(mem_type_e t, logic [31:0] wdata);
    case (t)
      MEM_BYTE: return {4{wdata[7:0]}};
      MEM_HALF: return {2{wdata[15:0]}};
      default:  return wdata;
    endcase
  endfunction

  function automatic logic [31:0] format_load(logic [31:0] word, rd_ctx_t ctx);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {ctx.lane, 3'b000});
    h = 16'(word >> {ctx.lane[1], 4'b0000});
    case (ctx.mtype)
      MEM_BYTE: return {{24{ctx.sign & b[7]}}, b};
      MEM_HALF: return {{16{ctx.sign & h[15]}}, h};
      default:  return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// MEM-stage access bus between the core (master) and the data-memory controller (slave).
// DMEM_PERF_EN adds the load/store counters ld_cnt and st_cnt.
interface dmem_ctrl_if;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_type;
  logic        mem_sign;
  logic        rmem;
  logic        wmem;
  logic [31:0] mem_rdata;
  logic        err;
  logic [31:0] err_addr;

`ifdef DMEM_PERF_EN
  logic [31:0] ld_cnt;
  logic [31:0] st_cnt;

  modport master (
    output mem_addr, mem_wdata, mem_type, mem_sign, rmem, wmem,
    input  mem_rdata, err, err_addr, ld_cnt, st_cnt
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_type, mem_sign, rmem, wmem,
    output mem_rdata, err, err_addr, ld_cnt, st_cnt
  );
`else
  modport master (
    output mem_addr, mem_wdata, mem_type, mem_sign, rmem, wmem,
    input  mem_rdata, err, err_addr
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_type, mem_sign, rmem, wmem,
    output mem_rdata, err, err_addr
  );
`endif

endinterface

// File: rtl/dmem_ram.sv
// Word-organised synchronous RAM: 2**DEPTH_LOG2 x 32, per-byte write enables,
// registered read port.
module dmem_ram
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [3:0]            we,
  input  logic [31:0]           wdata,
  input  logic                  re,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  // NOTE: no reset on the array or the read register; the controller's rd_valid
  // masks stale read data, and a resettable array would not map onto RAM macros.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: legality decode, byte-lane writes, one-cycle registered loads
// and a sticky error flag. DMEM_PERF_EN adds legal load/store counters.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int          DEPTH_LOG2 = DMEM_DEPTH_LOG2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  dmem_ctrl_if.slave  bus
);

  mem_type_e             mtype;
  logic [1:0]            lane;
  logic [31:0]           offset;
  logic                  in_range;
  logic                  any_req;
  logic                  legal;
  logic                  ld_ok;
  logic                  st_ok;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [3:0]            we;
  logic [31:0]           ram_rdata;
  logic                  rd_valid;
  rd_ctx_t               rd_ctx;
  logic                  err_q;
  logic [31:0]           err_addr_q;

  assign mtype    = mem_type_e'(bus.mem_type);
  assign lane     = bus.mem_addr[1:0];
  assign offset   = bus.mem_addr - BASE_ADDR;
  assign in_range = (bus.mem_addr >= BASE_ADDR) && ((offset >> (DEPTH_LOG2 + 2)) == 32'd0);
  assign any_req  = bus.rmem | bus.wmem;

  // Simultaneous rmem/wmem is illegal, so legality already requires exactly one request.
  assign legal    = (bus.rmem ^ bus.wmem) && (mtype != MEM_RSVD)
                    && is_aligned(mtype, lane) && in_range;
  assign ld_ok    = legal & bus.rmem;
  assign st_ok    = legal & bus.wmem;
  assign word_idx = offset[DEPTH_LOG2+1:2];

  // The RAM has no reset, so a store presented during reset must be blocked here.
  assign we = (st_ok && rstn) ? lane_enables(mtype, lane) : 4'b0000;

  dmem_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .addr  (word_idx),
    .we    (we),
    .wdata (lane_data(mtype, bus.mem_wdata)),
    .re    (ld_ok),
    .rdata (ram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_valid <= 1'b0;
      rd_ctx   <= '0;
    end else begin
      rd_valid <= ld_ok;
      if (ld_ok) rd_ctx <= '{lane: lane, mtype: mtype, sign: bus.mem_sign};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (any_req && !legal && !err_q) begin
      err_q      <= 1'b1;
      err_addr_q <= bus.mem_addr;
    end
  end

  // rd_valid clears asynchronously, so mem_rdata drops to zero the moment reset asserts.
  assign bus.mem_rdata = rd_valid ? format_load(ram_rdata, rd_ctx) : 32'd0;
  assign bus.err       = err_q;
  assign bus.err_addr  = err_addr_q;

`ifdef DMEM_PERF_EN
  logic [31:0] ld_cnt_q;
  logic [31:0] st_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      if (ld_ok) ld_cnt_q <= ld_cnt_q + 32'd1;
      if (st_ok) st_cnt_q <= st_cnt_q + 32'd1;
    end
  end

  assign bus.ld_cnt = ld_cnt_q;
  assign bus.st_cnt = st_cnt_q;
`endif

endmodule
